// File: rtl/and_latch.sv
// Registered bitwise AND of two operands with asynchronous active-low reset.
// Define AND_LATCH_SYNC_EN to add a 2-flop input synchronizer (latency 3).
module and_latch #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_chk
        $error("and_latch: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] r_out;

`ifdef AND_LATCH_SYNC_EN
    // Synchronizer stages clear to zero so no stale operand survives reset.
    logic [WIDTH-1:0] r_a_meta;
    logic [WIDTH-1:0] r_a_sync;
    logic [WIDTH-1:0] r_b_meta;
    logic [WIDTH-1:0] r_b_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_meta <= '0;
            r_a_sync <= '0;
            r_b_meta <= '0;
            r_b_sync <= '0;
        end else begin
            r_a_meta <= a_in;
            r_a_sync <= r_a_meta;
            r_b_meta <= b_in;
            r_b_sync <= r_b_meta;
        end
    end

    assign w_a = r_a_sync;
    assign w_b = r_b_sync;
`else
    assign w_a = a_in;
    assign w_b = b_in;
`endif

    assign w_and = w_a & w_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= RESET_VALUE;
        end else begin
            r_out <= w_and;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_and_latch.sv
// Randomized and directed bench for and_latch.
// Reference model: queue of operand products sampled at each live edge.
`timescale 1ns/1ps
module tb_and_latch;

    localparam int WIDTH = 1;
`ifdef AND_LATCH_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [WIDTH-1:0] RV = '0;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] a_in    = '0;
    logic [WIDTH-1:0] b_in    = '0;
    logic [WIDTH-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] tt_exp [4];

    and_latch #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RV)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .out    (dout)
    );

    always #10 clock = ~clock;

    // Keep the last LAT products captured while reset was released.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
        end else begin
            hist.push_back(a_in & b_in);
            if (hist.size() > LAT) void'(hist.pop_front());
        end
    end

    function automatic logic [WIDTH-1:0] model_out();
        if (hist.size() == 0) return RV;
        if (hist.size() < LAT) return '0;
        return hist[0];
    endfunction

    task automatic check(input string tag,
                         input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_check(input string tag, input int n);
        repeat (n) begin
            @(negedge clock);
            check(tag, dout, model_out());
        end
    endtask

    initial begin
        tt_exp[0] = '0;
        tt_exp[1] = '0;
        tt_exp[2] = '0;
        tt_exp[3] = '1;

        // Reset with operands 11 and running clock
        a_in = '1;
        b_in = '1;
        repeat (LAT + 2) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check("reset_async", dout, RV);
        repeat (4) begin
            @(posedge clock);
            #1 check("reset_hold_pos", dout, RV);
            @(negedge clock);
            check("reset_hold_neg", dout, RV);
        end

        // Release mid-cycle, then truth table
        a_in = '0;
        b_in = '0;
        #2 reset_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            @(negedge clock);
            a_in = p[1] ? '1 : '0;
            b_in = p[0] ? '1 : '0;
            run_check("truth_model", 25);
            check("truth_table", dout, tt_exp[p]);
        end

        // Latency from 00 to 11
        @(negedge clock);
        a_in = '0;
        b_in = '0;
        run_check("lat_pre", LAT + 2);
        @(posedge clock);
        #1 a_in = '1;
        b_in = '1;
        check("lat_edge0", dout, '0);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clock);
            #1 check("latency", dout, (k >= LAT) ? '1 : '0);
        end

        // Glitches on a_in between edges
        @(negedge clock);
        a_in = '0;
        b_in = '1;
        run_check("glitch_pre", LAT + 1);
        repeat (10) begin
            @(posedge clock);
            #4 a_in = '1;
            #4 check("glitch_mid", dout, '0);
            #4 a_in = '0;
            #4 check("glitch_after", dout, '0);
        end
        run_check("glitch_post", LAT + 2);

        // Random operand pairs, 500 time units each
        repeat (16) begin
            @(negedge clock);
            a_in = WIDTH'($urandom);
            b_in = WIDTH'($urandom);
            run_check("rand_model", 25);
            check("rand_steady", dout, a_in & b_in);
        end

        // Mid-run reset pulse of 3 ns with inputs 11
        @(negedge clock);
        a_in = '1;
        b_in = '1;
        run_check("mid_pre", LAT + 2);
        check("mid_one", dout, '1);
        @(posedge clock);
        #5 reset_n = 1'b0;
        #1 check("mid_async", dout, RV);
        #2 reset_n = 1'b1;
        #1 check("mid_released", dout, RV);
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clock);
            #1 check("mid_recover", dout, (k == LAT) ? '1 : '0);
        end
        run_check("mid_post", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_latch.md
AND_LATCH -- requirements
Module: and_latch

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 1: bit width of a_in, b_in and out; legal range 1..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default all-zeros: value loaded into out while reset is asserted; WIDTH bits.

Ports:
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge except reset.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low; integrators tie it to 1 when unused.
REQ-005 The block SHALL have port a_in, input, WIDTH bits: first AND operand.
REQ-006 The block SHALL have port b_in, input, WIDTH bits: second AND operand.
REQ-007 The block SHALL have port out, output, WIDTH bits: registered bitwise AND of a_in and b_in.
REQ-008 The block SHALL use exactly one clock and no other ports.

Function
REQ-009 On every rising clock edge with reset_n high, the capture register SHALL load (a_in & b_in), bitwise.
REQ-010 out SHALL be driven directly from a register, with no combinational path from a_in or b_in to out.
REQ-011 Latency SHALL be 1 clock edge from input change to out update when AND_LATCH_SYNC_EN is undefined.
REQ-012 Latency SHALL be 3 clock edges when AND_LATCH_SYNC_EN is defined.
REQ-013 out SHALL hold its value between rising edges regardless of input glitches between edges.
REQ-014 Inputs held constant for N cycles, with N at least the latency, SHALL yield a steady out equal to a_in & b_in.
REQ-015 Simultaneous change of a_in and b_in on the same cycle SHALL be captured as one combined operand pair; no intermediate value appears on out.
REQ-016 Each bit SHALL be independent: out[k] depends only on a_in[k] and b_in[k].
REQ-017 The truth table per bit SHALL be: 00->0, 01->0, 10->0, 11->1.
REQ-018 The block SHALL contain no latches, only edge-triggered flops.

Reset
REQ-019 Asserting reset_n low SHALL immediately, without waiting for clock, force out and every internal register to RESET_VALUE (synchronizer stages to 0).
REQ-020 While reset_n is low, out SHALL remain RESET_VALUE regardless of clock or inputs.
REQ-021 After reset_n rises, the first capture SHALL occur on the first rising clock edge with reset_n high.
REQ-022 Reset asserted mid-operation SHALL discard pending pipeline contents; no pre-reset operand may appear on out after release.

Configuration
REQ-023 The macro AND_LATCH_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer on each bit of a_in and b_in ahead of the AND/capture register, giving total latency 3 cycles and permitting asynchronous inputs.
REQ-024 When AND_LATCH_SYNC_EN is undefined, the inputs SHALL feed the AND/capture register directly, with latency 1 cycle and inputs required to be synchronous to clock.

Verification
REQ-025 The bench SHALL cover reset: reset_n=0 with a_in=1, b_in=1 and clock toggling -> out=0 throughout; async check: out=0 within the same timestep as reset_n falls.
REQ-026 The bench SHALL cover the truth table: after reset release, apply each of 00, 01, 10, 11, held 25 cycles each -> out = 0, 0, 0, 1 respectively after latency.
REQ-027 The bench SHALL cover latency: a_in=b_in=1 set just after an edge, macro undefined -> out=1 after exactly 1 edge; macro defined -> out=1 after exactly 3 edges.
REQ-028 The bench SHALL cover glitches: a_in pulses 1 between edges while b_in=1 and a_in=0 at every edge -> out stays 0.
REQ-029 The bench SHALL cover random compare: 16 random 1-bit operand pairs, each held 500 time units with a 20-unit clock period -> out equals a_in & b_in at each check; any mismatch fails.
REQ-030 The bench SHALL cover mid-run reset: with out=1, pulse reset_n low for 3 ns between edges -> out=0 immediately, then returns to 1 after latency with inputs still 11.
